usb3_ft601_rx: RTL and testbench



---
 rtl/usb3_ft601_rx_if.sv | 22 ++
 rtl/usb3_ft601_rx.sv | 66 ++++++
 tb/tb_usb3_ft601_rx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/usb3_ft601_rx_if.sv
// FT601 bus and dc32 FIFO write-side signals of the USB3 receive bridge.
// master is the bridge; slave is the FT601 chip plus the dc32 FIFO.
interface usb3_ft601_rx_if;
  logic        FR_RXF;
  logic        FT_OE;
  logic        FT_RD;
  logic [31:0] usb3_data_in;
  logic        write_to_dc32_fifo;
  logic [31:0] dc32_fifo_data_in;
  logic        dc32_fifo_almost_full;
  logic        dc32_fifo_empty;

  modport master (
    input  FR_RXF, usb3_data_in, dc32_fifo_almost_full, dc32_fifo_empty,
    output FT_OE, FT_RD, write_to_dc32_fifo, dc32_fifo_data_in
  );

  modport slave (
    output FR_RXF, usb3_data_in, dc32_fifo_almost_full, dc32_fifo_empty,
    input  FT_OE, FT_RD, write_to_dc32_fifo, dc32_fifo_data_in
  );
endinterface

// File: rtl/usb3_ft601_rx.sv
// FT601 245-sync-FIFO receive bridge: drives OE_N/RD_N from RXF_N and forwards
// each word read into the dc32 FIFO, armed once per frame.
module usb3_ft601_rx (
  input  logic                  fpga_clk,
  input  logic                  reset_per_frame,
  input  logic                  buffer_switch_done,
  input  logic                  ftdi_clk,
  usb3_ft601_rx_if.master       bus
);

  typedef enum logic [1:0] {WAIT_FRAME, IDLE, OE, READ} state_t;

  state_t      state_q, state_d;
  logic        ft_oe_q, ft_oe_d;
  logic        ft_rd_q, ft_rd_d;
  logic        wr_q, wr_d;
  logic [31:0] data_q, data_d;

  // fpga_clk shares ftdi_clk's source; kept only for port compatibility.
  logic unused_fpga_clk;
  assign unused_fpga_clk = fpga_clk;

  logic go;
  assign go = !bus.FR_RXF && !bus.dc32_fifo_almost_full;

  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    case (state_q)
      WAIT_FRAME: if (buffer_switch_done && bus.dc32_fifo_empty) state_d = IDLE;
      IDLE:       if (go) state_d = OE;
      OE:         state_d = go ? READ : IDLE;
      READ: begin
        // A word on the bus is taken even when almost_full forces the exit.
        if (!bus.FR_RXF) begin
          wr_d   = 1'b1;
          data_d = bus.usb3_data_in;
        end
        if (!go) state_d = IDLE;
      end
      default:    state_d = WAIT_FRAME;
    endcase
    if (reset_per_frame) begin
      state_d = WAIT_FRAME;
      wr_d    = 1'b0;
      data_d  = '0;
    end
    ft_oe_d = !(state_d == OE || state_d == READ);
    ft_rd_d = !(state_d == READ);
  end

  always_ff @(posedge ftdi_clk) begin
    state_q <= state_d;
    ft_oe_q <= ft_oe_d;
    ft_rd_q <= ft_rd_d;
    wr_q    <= wr_d;
    data_q  <= data_d;
  end

  assign bus.FT_OE              = ft_oe_q;
  assign bus.FT_RD              = ft_rd_q;
  assign bus.write_to_dc32_fifo = wr_q;
  assign bus.dc32_fifo_data_in  = data_q;

endmodule

// File: tb/tb_usb3_ft601_rx.sv
// Directed bench for usb3_ft601_rx with a scoreboard of expected dc32 writes.
module tb_usb3_ft601_rx;
  logic clk = 1'b0;
  logic reset_per_frame;
  logic buffer_switch_done;

  usb3_ft601_rx_if bus ();

  usb3_ft601_rx dut (
    .fpga_clk           (clk),
    .reset_per_frame    (reset_per_frame),
    .buffer_switch_done (buffer_switch_done),
    .ftdi_clk           (clk),
    .bus                (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then score any write the DUT made on that edge.
  task automatic tick();
    logic [31:0] exp;
    @(posedge clk);
    #1;
    if (bus.write_to_dc32_fifo === 1'b1) begin
      writes++;
      if (sb.size() == 0) begin
        chk("unexpected_write", bus.dc32_fifo_data_in, 32'hxxxxxxxx);
      end else begin
        exp = sb.pop_front();
        chk("write_data", bus.dc32_fifo_data_in, exp);
      end
    end
  endtask

  task automatic chk_strobes(input string tag, input logic oe, input logic rd);
    chk({tag, "_oe"}, {31'd0, bus.FT_OE}, {31'd0, oe});
    chk({tag, "_rd"}, {31'd0, bus.FT_RD}, {31'd0, rd});
  endtask

  initial begin
    int w0;
    reset_per_frame           = 1'b1;
    buffer_switch_done        = 1'b0;
    bus.FR_RXF                = 1'b1;
    bus.usb3_data_in          = 32'h0;
    bus.dc32_fifo_almost_full = 1'b0;
    bus.dc32_fifo_empty       = 1'b0;
    tick(); tick();
    chk_strobes("reset", 1'b1, 1'b1);
    chk("reset_wr", {31'd0, bus.write_to_dc32_fifo}, 32'd0);
    chk("reset_data", bus.dc32_fifo_data_in, 32'h0);

    // Not armed: data available but no buffer switch yet
    reset_per_frame = 1'b0;
    bus.FR_RXF      = 1'b0;
    repeat (6) tick();
    chk_strobes("unarmed", 1'b1, 1'b1);

    // Switch done but FIFO not empty: still no arming
    buffer_switch_done = 1'b1;
    repeat (4) tick();
    chk_strobes("not_empty", 1'b1, 1'b1);

    // Arm: WAIT_FRAME->IDLE, then OE one cycle later, RD two cycles later
    bus.FR_RXF          = 1'b1;
    bus.dc32_fifo_empty = 1'b1;
    tick();
    chk_strobes("armed_idle", 1'b1, 1'b1);
    bus.dc32_fifo_empty = 1'b0;
    buffer_switch_done  = 1'b0;
    bus.FR_RXF          = 1'b0;
    tick();
    chk_strobes("edge1_oe", 1'b0, 1'b1);
    tick();
    chk_strobes("edge2_read", 1'b0, 1'b0);
    chk("no_write_yet", {31'd0, bus.write_to_dc32_fifo}, 32'd0);

    // Burst of 4 words
    w0 = writes;
    for (int i = 1; i <= 4; i++) begin
      bus.usb3_data_in = 32'(i);
      sb.push_back(32'(i));
      tick();
      chk("burst_wr_pulse", {31'd0, bus.write_to_dc32_fifo}, 32'd1);
    end
    bus.FR_RXF       = 1'b1;
    bus.usb3_data_in = 32'hFFFF0000;
    tick();
    chk_strobes("burst_end", 1'b1, 1'b1);
    repeat (3) tick();
    chk("burst_count", 32'(writes - w0), 32'd4);
    chk("data_hold", bus.dc32_fifo_data_in, 32'h4);

    // Almost full raised mid-READ while a word is on the bus
    bus.FR_RXF = 1'b0;
    tick(); tick();
    chk_strobes("af_read", 1'b0, 1'b0);
    bus.usb3_data_in          = 32'hDEADBEEF;
    bus.dc32_fifo_almost_full = 1'b1;
    sb.push_back(32'hDEADBEEF);
    w0 = writes;
    tick();
    chk("af_last_word", 32'(writes - w0), 32'd1);
    chk_strobes("af_exit", 1'b1, 1'b1);
    bus.usb3_data_in = 32'h12345678;
    repeat (5) tick();
    chk_strobes("af_hold", 1'b1, 1'b1);
    chk("af_no_more", 32'(writes - w0), 32'd1);

    // Release almost full -> OE, then FR_RXF rises in OE -> back to IDLE
    bus.dc32_fifo_almost_full = 1'b0;
    tick();
    chk_strobes("oe_again", 1'b0, 1'b1);
    bus.FR_RXF = 1'b1;
    w0 = writes;
    tick();
    chk_strobes("oe_abort", 1'b1, 1'b1);
    repeat (3) tick();
    chk("oe_abort_writes", 32'(writes - w0), 32'd0);

    // Reset mid-burst: word on the bus is dropped
    bus.FR_RXF = 1'b0;
    tick(); tick();
    chk_strobes("rst_read", 1'b0, 1'b0);
    bus.usb3_data_in = 32'h55AA55AA;
    reset_per_frame  = 1'b1;
    w0 = writes;
    tick();
    chk_strobes("rst_mid", 1'b1, 1'b1);
    chk("rst_mid_wr", {31'd0, bus.write_to_dc32_fifo}, 32'd0);
    chk("rst_mid_data", bus.dc32_fifo_data_in, 32'h0);
    reset_per_frame = 1'b0;
    repeat (4) tick();
    chk_strobes("rst_unarmed", 1'b1, 1'b1);
    buffer_switch_done = 1'b1;
    repeat (3) tick();
    chk_strobes("rst_not_empty", 1'b1, 1'b1);
    chk("rst_writes", 32'(writes - w0), 32'd0);
    bus.dc32_fifo_empty = 1'b1;
    tick();
    chk_strobes("rearm_idle", 1'b1, 1'b1);
    tick();
    chk_strobes("rearm_oe", 1'b0, 1'b1);
    bus.FR_RXF = 1'b1;
    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
